// File: rtl/alu_mc.sv
// Registered, handshaked execute-stage ALU with an iterative shift-add multiplier.
// Define ALU_MC_MUL_EN to make MUL (1010) legal; otherwise 1010 decodes as illegal.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       SR,
    output logic             illegal
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_sr;
    logic             r_ill;

    logic             w_accept;
    logic             w_mul;
    logic             w_ill;
    logic             w_c, w_v;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;

`ifdef ALU_MC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mul_done;
    assign w_mul_done = (r_state == S_BUSY) && (r_cnt == '0);
`endif

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign SR        = r_sr;
    assign illegal   = r_ill;

    always_comb begin
        w_ill = 1'b0;
        w_mul = 1'b0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_sum = '0;
        w_res = '0;
        case (exe_cmd)
            4'b0001: w_res = val2;
            4'b1001: w_res = ~val2;
            4'b0010, 4'b0011: begin
                w_sum = {1'b0, val1} + {1'b0, val2}
                      + ((exe_cmd[0]) ? {{WIDTH{1'b0}}, cin} : '0);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (val1[WIDTH-1] == val2[WIDTH-1]) && (w_res[WIDTH-1] != val1[WIDTH-1]);
            end
            4'b0100, 4'b0101: begin
                // SUB adds the implicit +1; SBC substitutes cin for it (C=1 means no borrow)
                w_sum = {1'b0, val1} + {1'b0, ~val2}
                      + ((exe_cmd[0]) ? {{WIDTH{1'b0}}, cin} : {{WIDTH{1'b0}}, 1'b1});
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (val1[WIDTH-1] != val2[WIDTH-1]) && (w_res[WIDTH-1] != val1[WIDTH-1]);
            end
            4'b0110: w_res = val1 & val2;
            4'b0111: w_res = val1 | val2;
            4'b1000: w_res = val1 ^ val2;
`ifdef ALU_MC_MUL_EN
            4'b1010: w_mul = 1'b1;
`endif
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_next = w_mul ? S_BUSY : S_DONE;
                else if ((r_state == S_DONE) && out_ready)
                    w_next = S_IDLE;
            end
`ifdef ALU_MC_MUL_EN
            S_BUSY: if (w_mul_done) w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_sr     <= '0;
            r_ill    <= 1'b0;
        end else if (w_accept && !w_mul) begin
            r_result <= w_res;
            r_sr     <= {(w_res == '0), w_c, w_res[WIDTH-1], w_v};
            r_ill    <= w_ill;
`ifdef ALU_MC_MUL_EN
        end else if (w_mul_done) begin
            r_result <= r_acc;
            r_sr     <= {(r_acc == '0), 1'b0, r_acc[WIDTH-1], 1'b0};
            r_ill    <= 1'b0;
`endif
        end
    end

`ifdef ALU_MC_MUL_EN
    // One multiplier bit per cycle; the cnt==0 cycle only publishes the product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_mul) begin
            r_acc    <= '0;
            r_mcand  <= val1;
            r_mplier <= val2;
            r_cnt    <= CNT_W'(WIDTH);
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc: table of single-cycle ops plus handshake,
// multi-cycle MUL and reset corner sequences.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  exe_cmd;
    logic [31:0] val1, val2;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  SR;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .SR(SR), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic [31:0] a, b;
        logic        ci;
        logic [31:0] res;
        logic [3:0]  sr;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] r, input logic [3:0] s, input logic il);
        vec_t v;
        v.name = n; v.cmd = c; v.a = a; v.b = b; v.ci = ci; v.res = r; v.sr = s; v.ill = il;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {out_valid, illegal, SR, result}
    function automatic logic [63:0] obs();
        return {26'd0, out_valid, illegal, SR, result};
    endfunction

    function automatic logic [63:0] want(input logic ov, input logic il, input logic [3:0] s, input logic [31:0] r);
        return {26'd0, ov, il, s, r};
    endfunction

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic ci);
        in_valid = 1'b1; exe_cmd = c; val1 = a; val2 = b; cin = ci;
    endtask

    task automatic run_mul(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [3:0] s);
        int  k;
        bit  busy_ready;
        out_ready = 1'b0;
        drive(4'b1010, a, b, 1'b0);
        tick();
        in_valid = 1'b0;
        val1 = 32'hDEAD_BEEF; val2 = 32'h1234_5678;
        k = 0; busy_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin k = i; break; end
            if (in_ready) busy_ready = 1'b1;
        end
        chk({n, " latency"}, 64'(k), 64'd33);
        chk({n, " in_ready in BUSY"}, 64'(busy_ready), 64'd0);
        repeat (4) tick();
        chk({n, " held"}, obs(), want(1'b1, 1'b0, s, r));
        out_ready = 1'b1;
        tick();
        chk({n, " drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; exe_cmd = 4'b0; val1 = '0; val2 = '0; cin = 1'b0; out_ready = 1'b1;

        add("ADD wrap",    4'b0010, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         4'b1100, 1'b0);
        add("SUB borrow",  4'b0100, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 4'b0010, 1'b0);
        add("SUB ovf",     4'b0100, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 4'b0101, 1'b0);
        add("SUB equal",   4'b0100, 32'd5,         32'd5,         1'b0, 32'h0,         4'b1100, 1'b0);
        add("SBC cin0",    4'b0101, 32'd10,        32'd3,         1'b0, 32'd6,         4'b0100, 1'b0);
        add("SBC cin0 eq", 4'b0101, 32'd5,         32'd5,         1'b0, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        add("SBC cin1 eq", 4'b0101, 32'd5,         32'd5,         1'b1, 32'h0,         4'b1100, 1'b0);
        add("ADC ovf",     4'b0011, 32'h7FFF_FFFF, 32'h0,         1'b1, 32'h8000_0000, 4'b0011, 1'b0);
        add("ADC wrap",    4'b0011, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         4'b1100, 1'b0);
        add("ADD ovf",     4'b0010, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 4'b0011, 1'b0);
        add("AND",         4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h00F0_00F0, 4'b0000, 1'b0);
        add("ORR",         4'b0111, 32'h00FF_0000, 32'h0000_FF00, 1'b0, 32'h00FF_FF00, 4'b0000, 1'b0);
        add("EOR",         4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'h0,         4'b1000, 1'b0);
        add("MOV",         4'b0001, 32'h1234_5678, 32'h8000_0001, 1'b1, 32'h8000_0001, 4'b0010, 1'b0);
        add("MVN",         4'b1001, 32'h1234_5678, 32'h0,         1'b0, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        add("ILL 1111",    4'b1111, 32'h1,         32'h2,         1'b1, 32'h0,         4'b1000, 1'b1);
        add("ILL 0000",    4'b0000, 32'hFFFF_FFFF, 32'h3,         1'b0, 32'h0,         4'b1000, 1'b1);
`ifndef ALU_MC_MUL_EN
        add("ILL 1010",    4'b1010, 32'd7,         32'd6,         1'b0, 32'h0,         4'b1000, 1'b1);
`endif

        #12;
        chk("reset outputs", obs(), want(1'b0, 1'b0, 4'b0000, 32'h0));
        chk("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].ci);
            tick();
            in_valid = 1'b0;
            chk(tbl[i].name, obs(), want(1'b1, tbl[i].ill, tbl[i].sr, tbl[i].res));
        end
        tick();
        chk("idle after drain", 64'(out_valid), 64'd0);

        // back-to-back single-cycle ops
        @(negedge clk);
        drive(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        tick();
        chk("b2b AND", obs(), want(1'b1, 1'b0, 4'b0000, 32'h00F0_00F0));
        chk("b2b ready", 64'(in_ready), 64'd1);
        drive(4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("b2b EOR", obs(), want(1'b1, 1'b0, 4'b1000, 32'h0));
        tick();

        // result held under backpressure; new bundles refused
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd2, 1'b0);
        tick();
        drive(4'b0100, 32'd9, 32'd1, 1'b0);
        repeat (3) tick();
        chk("stall held", obs(), want(1'b1, 1'b0, 4'b0000, 32'd3));
        chk("stall in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall release", 64'(out_valid), 64'd0);

        // reset while in DONE
        out_ready = 1'b0;
        drive(4'b0111, 32'h55, 32'hAA, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst in DONE", obs(), want(1'b0, 1'b0, 4'b0000, 32'h0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

`ifdef ALU_MC_MUL_EN
        run_mul("MUL 7x6", 32'd7, 32'd6, 32'd42, 4'b0000);
        run_mul("MUL max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000);
        run_mul("MUL zero", 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b1000);
        run_mul("MUL neg", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b0010);

        // leave a nonzero result so the reset check is meaningful
        @(negedge clk);
        drive(4'b0001, 32'h0, 32'h77, 1'b0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(4'b1010, 32'd3, 32'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1 chk("rst mid-MUL", obs(), want(1'b0, 1'b0, 4'b0000, 32'h0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst mid-MUL ready", 64'(in_ready), 64'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 45; i++) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            chk("rst mid-MUL no result", 64'(seen), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
